mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 140 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences a fixed multi-cycle latency
// for mult/div, and stalls HI/LO consumers in D while an operation is pending.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_UseMD,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state_q;
    logic [31:0] hi_q, lo_q, res_hi_q, res_lo_q;
    logic        wr_q, busy_q;
    logic [CW-1:0] cnt_q;

    op_e         op;
    logic        is_md;
    logic [63:0] prod_u;
    logic signed [63:0] prod_s;
    logic [31:0] a_mag, b_mag, sq_mag, sr_mag;
    logic [31:0] res_hi_d, res_lo_d;
    logic        wr_d;

    assign op    = op_e'(MDOp);
    assign is_md = Start && (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
    assign Stall = D_UseMD && (busy_q || is_md);
    assign Busy  = busy_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

    assign prod_u = {32'd0, A} * {32'd0, B};
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

    // Signed divide on magnitudes so 0x80000000 / -1 never overflows a signed divider.
    always_comb begin
        a_mag    = A[31] ? (~A + 32'd1) : A;
        b_mag    = B[31] ? (~B + 32'd1) : B;
        sq_mag   = (b_mag != '0) ? a_mag / b_mag : '0;
        sr_mag   = (b_mag != '0) ? a_mag % b_mag : '0;
        res_hi_d = '0;
        res_lo_d = '0;
        wr_d     = 1'b0;
        case (op)
            OP_MULT: begin
                res_hi_d = prod_s[63:32];
                res_lo_d = prod_s[31:0];
                wr_d     = 1'b1;
            end
            OP_MULTU: begin
                res_hi_d = prod_u[63:32];
                res_lo_d = prod_u[31:0];
                wr_d     = 1'b1;
            end
            OP_DIV: begin
                res_lo_d = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
                res_hi_d = A[31] ? (~sr_mag + 32'd1) : sr_mag;
                wr_d     = (B != '0);
            end
            OP_DIVU: begin
                res_lo_d = (B != '0) ? A / B : '0;
                res_hi_d = (B != '0) ? A % B : '0;
                wr_d     = (B != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                res_hi_q <= res_hi_d;
                                res_lo_q <= res_lo_d;
                                wr_q     <= wr_d;
                                cnt_q    <= (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_CYCLES)
                                                                            : CW'(MULT_CYCLES);
                                busy_q   <= 1'b1;
                                state_q  <= BUSY;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        if (wr_q) begin
                            hi_q <= res_hi_q;
                            lo_q <= res_lo_q;
                        end
                        wr_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO pairs are queued at issue and
// popped when Busy falls; latency and Stall are checked along the way.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset, Start, D_UseMD;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        Busy, Stall;
    logic [31:0] HI, LO;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [63:0] exp_q[$];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .D_UseMD(D_UseMD), .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one Start cycle; optionally verify combinational Stall before the edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit use_md, input logic exp_stall);
        Start = 1'b1; MDOp = op; A = a; B = b; D_UseMD = use_md;
        #1;
        if (use_md) chk("stall_start", {63'd0, Stall}, {63'd0, exp_stall});
        step();
        Start = 1'b0; MDOp = 3'b000;
    endtask

    task automatic wait_done(input string tag, input int unsigned exp_n, input bit stall_chk);
        int unsigned n = 0;
        logic [63:0] e;
        while (Busy && n < 100) begin
            if (stall_chk) chk("stall_busy", {63'd0, Stall}, 64'd1);
            n++;
            step();
        end
        chk({tag, "_cycles"}, 64'(n), 64'(exp_n));
        if (stall_chk) chk("stall_after", {63'd0, Stall}, 64'd0);
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_hilo"}, {HI, LO}, e);
        end
        D_UseMD = 1'b0;
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDOp = '0; A = '0; B = '0; D_UseMD = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("reset_hilo", {HI, LO}, 64'd0);
        chk("reset_busy", {63'd0, Busy}, 64'd0);

        // multu, no stall observation
        exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk("multu_busy_rise", {63'd0, Busy}, 64'd1);
        wait_done("multu", 5, 1'b0);

        // mult -3*4 with D_UseMD held high
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF4});
        issue(3'b001, 32'hFFFF_FFFD, 32'd4, 1'b1, 1'b1);
        D_UseMD = 1'b1;
        wait_done("mult", 5, 1'b1);

        // signed div -7/2
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        wait_done("div", 10, 1'b0);

        // signed div overflow case
        exp_q.push_back({32'h0000_0000, 32'h8000_0000});
        issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_done("div_ovf", 10, 1'b0);

        // mthi/mtlo; mthi must not raise Stall
        issue(3'b101, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        chk("mthi_hi", {32'd0, HI}, {32'd0, 32'h1234_5678});
        chk("mthi_busy", {63'd0, Busy}, 64'd0);
        issue(3'b110, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
        chk("mtlo_hilo", {HI, LO}, {32'h1234_5678, 32'h9ABC_DEF0});
        chk("mtlo_busy", {63'd0, Busy}, 64'd0);

        // divu by zero keeps prior HI/LO
        issue(3'b101, 32'h11, 32'd0, 1'b0, 1'b0);
        issue(3'b110, 32'h22, 32'd0, 1'b0, 1'b0);
        exp_q.push_back({32'h11, 32'h22});
        issue(3'b100, 32'd7, 32'd0, 1'b0, 1'b0);
        wait_done("divu_zero", 10, 1'b0);

        // reset during busy cycle 4 aborts with no later write
        issue(3'b011, 32'd100, 32'd7, 1'b0, 1'b0);
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", {63'd0, Busy}, 64'd0);
        chk("abort_hilo", {HI, LO}, 64'd0);
        for (int i = 0; i < 12; i++) step();
        chk("abort_nowrite", {HI, LO}, 64'd0);

        // Start mult while busy with a div is ignored
        exp_q.push_back({32'd2, 32'd14});
        issue(3'b011, 32'd100, 32'd7, 1'b0, 1'b0);
        step();
        Start = 1'b1; MDOp = 3'b001; A = 32'd3; B = 32'd3;
        step();
        Start = 1'b0; MDOp = 3'b000;
        chk("ign_hilo_mid", {HI, LO}, 64'd0);
        wait_done("ignored", 8, 1'b0);

        // back-to-back: issue in the first cycle Busy is low
        exp_q.push_back({32'd0, 32'd42});
        issue(3'b010, 32'd6, 32'd7, 1'b0, 1'b0);
        chk("b2b_busy", {63'd0, Busy}, 64'd1);
        wait_done("b2b", 5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
